downstream_vc_tracker: RTL and testbench

//  Per-output-port bookkeeping of downstream VCs for the router: tracks credits of every

---
 rtl/downstream_vc_tracker.sv | 137 +++++++++++++
 tb/tb_downstream_vc_tracker.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/downstream_vc_tracker.sv
// downstream_vc_tracker: per output port, tracks the credit count of every downstream
// VC buffer and the IDLE/ALLOC/DRAINING life cycle of each downstream VC.
// Optional feature macro: TRACKER_ERROR_EN adds a sticky protocol-violation flag on
// error_o plus simulation $error reports; without it error_o is tied low.
module downstream_vc_tracker #(
  parameter int unsigned PORT_NUM    = 5,
  parameter int unsigned VC_NUM      = 2,
  parameter int unsigned BUFFER_SIZE = 8,
  localparam int unsigned VC_SIZE    = (VC_NUM > 1) ? $clog2(VC_NUM) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PORT_NUM-1:0][VC_NUM-1:0]     vc_alloc_i,
  input  logic [PORT_NUM-1:0]                 flit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]    flit_vc_i,
  input  logic [PORT_NUM-1:0]                 flit_tail_i,
  input  logic [PORT_NUM-1:0]                 credit_valid_i,
  input  logic [PORT_NUM-1:0][VC_SIZE-1:0]    credit_vc_i,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]     credit_available_o,
  output logic [PORT_NUM-1:0][VC_NUM-1:0]     idle_downstream_vc_o,
  output logic                                error_o
);

  localparam int unsigned CNT_W = $clog2(BUFFER_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_SIZE);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ALLOC    = 2'd1;
  localparam logic [1:0] DRAINING = 2'd2;

  logic [PORT_NUM-1:0][VC_NUM-1:0][1:0]       state_q, state_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]            send_c, credit_c;

  // Decode the per-port send/credit strobes into per-VC events.
  always_comb begin
    send_c   = '0;
    credit_c = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        send_c[p][v]   = flit_valid_i[p]   && (flit_vc_i[p]   == VC_SIZE'(v));
        credit_c[p][v] = credit_valid_i[p] && (credit_vc_i[p] == VC_SIZE'(v));
      end
    end
  end

  // Next credit count (saturating) and next life-cycle state per downstream VC.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (send_c[p][v] && !credit_c[p][v] && (cnt_q[p][v] != '0)) begin
          cnt_d[p][v] = cnt_q[p][v] - CNT_W'(1);
        end else if (credit_c[p][v] && !send_c[p][v] && (cnt_q[p][v] != CNT_FULL)) begin
          cnt_d[p][v] = cnt_q[p][v] + CNT_W'(1);
        end

        case (state_q[p][v])
          IDLE: begin
            if (vc_alloc_i[p][v]) state_d[p][v] = ALLOC;
          end
          ALLOC: begin
            if (send_c[p][v] && flit_tail_i[p]) state_d[p][v] = DRAINING;
          end
          DRAINING: begin
            if (cnt_d[p][v] == CNT_FULL) state_d[p][v] = IDLE;
          end
          default: state_d[p][v] = IDLE;
        endcase
      end
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        for (int unsigned v = 0; v < VC_NUM; v++) begin
          state_q[p][v] <= IDLE;
          cnt_q[p][v]   <= CNT_FULL;
        end
      end
      credit_available_o   <= '1;
      idle_downstream_vc_o <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        for (int unsigned v = 0; v < VC_NUM; v++) begin
          credit_available_o[p][v]   <= (cnt_d[p][v] != '0);
          idle_downstream_vc_o[p][v] <= (state_d[p][v] == IDLE);
        end
      end
    end
  end

`ifdef TRACKER_ERROR_EN
  logic [PORT_NUM-1:0][VC_NUM-1:0] viol_c;

  // Protocol violations: underflow, overflow, alloc of a busy VC, send on an unallocated VC.
  always_comb begin
    viol_c = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        viol_c[p][v] = (send_c[p][v] && !credit_c[p][v] && (cnt_q[p][v] == '0))
                    || (credit_c[p][v] && !send_c[p][v] && (cnt_q[p][v] == CNT_FULL))
                    || (vc_alloc_i[p][v] && (state_q[p][v] != IDLE))
                    || (send_c[p][v] && (state_q[p][v] == IDLE) && !vc_alloc_i[p][v]);
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      error_o <= 1'b0;
    end else if (|viol_c) begin
      error_o <= 1'b1;
    end
  end

  // Simulation report naming the offending port/VC.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < PORT_NUM; p++) begin
        for (int unsigned v = 0; v < VC_NUM; v++) begin
          if (viol_c[p][v]) $error("downstream_vc_tracker: protocol violation port %0d vc %0d", p, v);
        end
      end
    end
  end
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_downstream_vc_tracker.sv
// Scoreboard bench for downstream_vc_tracker: a stimulus process runs a behavioural
// model and queues the expected outputs; a monitor pops and compares each cycle.
module tb_downstream_vc_tracker;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int B  = 8;
  localparam int VS = 1;

  typedef struct packed {
    logic [P*V-1:0] ca;
    logic [P*V-1:0] idle;
    logic           err;
  } exp_t;

  typedef enum {M_IDLE, M_ALLOC, M_DRAIN} mst_e;

  logic clk = 1'b0;
  logic rst;
  logic [P-1:0][V-1:0]  vc_alloc;
  logic [P-1:0]         flit_valid;
  logic [P-1:0][VS-1:0] flit_vc;
  logic [P-1:0]         flit_tail;
  logic [P-1:0]         credit_valid;
  logic [P-1:0][VS-1:0] credit_vc;
  logic [P-1:0][V-1:0]  credit_available;
  logic [P-1:0][V-1:0]  idle_vc;
  logic                 error;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  int   m_cnt[P][V];
  mst_e m_st[P][V];
  bit   m_err;

  always #5 clk = ~clk;

  downstream_vc_tracker #(.PORT_NUM(P), .VC_NUM(V), .BUFFER_SIZE(B)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .vc_alloc_i           (vc_alloc),
    .flit_valid_i         (flit_valid),
    .flit_vc_i            (flit_vc),
    .flit_tail_i          (flit_tail),
    .credit_valid_i       (credit_valid),
    .credit_vc_i          (credit_vc),
    .credit_available_o   (credit_available),
    .idle_downstream_vc_o (idle_vc),
    .error_o              (error)
  );

  // Advance the reference model by one clock using the inputs now applied; queue its outputs.
  task automatic model_push();
    exp_t e;
    if (!rst) begin
      foreach (m_cnt[p, v]) begin
        m_cnt[p][v] = B;
        m_st[p][v]  = M_IDLE;
      end
      m_err = 1'b0;
    end else begin
      foreach (m_cnt[p, v]) begin
        bit snd, crd, alc;
        int nc;
        snd = flit_valid[p] && (int'(flit_vc[p]) == v);
        crd = credit_valid[p] && (int'(credit_vc[p]) == v);
        alc = vc_alloc[p][v];
        if (snd && !crd && m_cnt[p][v] == 0) m_err = 1'b1;
        if (crd && !snd && m_cnt[p][v] == B) m_err = 1'b1;
        if (alc && m_st[p][v] != M_IDLE) m_err = 1'b1;
        if (snd && m_st[p][v] == M_IDLE && !alc) m_err = 1'b1;
        nc = m_cnt[p][v] + int'(crd) - int'(snd);
        if (nc < 0) nc = 0;
        if (nc > B) nc = B;
        if (m_st[p][v] == M_IDLE && alc) m_st[p][v] = M_ALLOC;
        else if (m_st[p][v] == M_ALLOC && snd && flit_tail[p]) m_st[p][v] = M_DRAIN;
        else if (m_st[p][v] == M_DRAIN && nc == B) m_st[p][v] = M_IDLE;
        m_cnt[p][v] = nc;
      end
    end
    foreach (m_cnt[p, v]) begin
      e.ca[p*V+v]   = (m_cnt[p][v] != 0);
      e.idle[p*V+v] = (m_st[p][v] == M_IDLE);
    end
`ifdef TRACKER_ERROR_EN
    e.err = m_err;
`else
    e.err = 1'b0;
`endif
    q.push_back(e);
  endtask

  task automatic clr();
    rst          = 1'b1;
    vc_alloc     = '0;
    flit_valid   = '0;
    flit_vc      = '0;
    flit_tail    = '0;
    credit_valid = '0;
    credit_vc    = '0;
  endtask

  task automatic cyc();
    model_push();
    @(negedge clk);
    clr();
  endtask

  task automatic alloc(input int p, input int v);
    vc_alloc[p][v] = 1'b1;
  endtask

  task automatic send(input int p, input int v, input bit tail);
    flit_valid[p] = 1'b1;
    flit_vc[p]    = VS'(v);
    flit_tail[p]  = tail;
  endtask

  task automatic credit(input int p, input int v);
    credit_valid[p] = 1'b1;
    credit_vc[p]    = VS'(v);
  endtask

  // Monitor: compares DUT outputs against the queued expectation after every clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (credit_available !== e.ca) begin
          n_fail++;
          $display("FAIL credit_available t=%0t got %b exp %b", $time, credit_available, e.ca);
        end
        n_tests++;
        if (idle_vc !== e.idle) begin
          n_fail++;
          $display("FAIL idle_downstream_vc t=%0t got %b exp %b", $time, idle_vc, e.idle);
        end
        n_tests++;
        if (error !== e.err) begin
          n_fail++;
          $display("FAIL error t=%0t got %b exp %b", $time, error, e.err);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized traffic.
  initial begin
    int k;
    clr();
    rst = 1'b0;
    @(negedge clk);

    // reset then idle cycles
    rst = 1'b0; cyc();
    rst = 1'b0; cyc();
    cyc(); cyc();

    // packet of 3 flits on p1v0, then its credits come back
    alloc(1, 0); cyc();
    send(1, 0, 0); cyc();
    send(1, 0, 0); cyc();
    send(1, 0, 1); cyc();
    cyc();
    repeat (3) begin credit(1, 0); cyc(); end
    cyc();

    // exhaust p0v1, refill to 4, then simultaneous send+credit
    alloc(0, 1); cyc();
    repeat (8) begin send(0, 1, 0); cyc(); end
    cyc();
    repeat (4) begin credit(0, 1); cyc(); end
    send(0, 1, 0); credit(0, 1); cyc();
    send(0, 1, 1); cyc();
    repeat (5) begin credit(0, 1); cyc(); end
    cyc();

    // head-tail flit on p2v0 with credit next cycle
    alloc(2, 0); cyc();
    send(2, 0, 1); cyc();
    credit(2, 0); cyc();
    cyc();

    // overflow credit on p3v0; error stays until reset
    credit(3, 0); cyc();
    cyc(); cyc();
    rst = 1'b0; cyc();
    cyc();

    // reset in the middle of a drain on p4v1 (cnt 2, DRAINING)
    alloc(4, 1); cyc();
    repeat (5) begin send(4, 1, 0); cyc(); end
    send(4, 1, 1); cyc();
    cyc();
    rst = 1'b0; cyc();
    cyc(); cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(299) == 0) begin
        rst = 1'b0;
      end else begin
        for (int p = 0; p < P; p++) begin
          if ($urandom_range(3) == 0) vc_alloc[p][$urandom_range(V-1)] = 1'b1;
          if ($urandom_range(1) == 0) send(p, int'($urandom_range(V-1)), ($urandom_range(2) == 0));
          if ($urandom_range(1) == 0) credit(p, int'($urandom_range(V-1)));
        end
      end
      cyc();
    end

    k = 0;
    while (q.size() > 0 && k < 10) begin
      @(posedge clk);
      #3;
      k++;
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending %0d exp 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
